// File: rtl/pool_ball_pkg.sv
// Shared types and helpers for the pool-table ball motion scheduler.
package pool_ball_pkg;

  localparam int MAX_BALLS = 8;
  localparam int VEL_MAX   = 31;

  typedef logic [10:0]        coord_t;
  typedef logic signed [5:0]  vel_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    vel_t   vx;
    vel_t   vy;
  } ball_state_t;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } sched_state_e;

  // Reverse a velocity for a cushion bounce; -32 has no positive twin, so clamp to +31.
  function automatic vel_t neg_sat(input vel_t v);
    if (v == vel_t'(-VEL_MAX - 1)) begin
      return vel_t'(VEL_MAX);
    end
    return -v;
  endfunction

  // Move a velocity component one step toward zero (friction).
  function automatic vel_t toward_zero(input vel_t v);
    if (v > 0) begin
      return v - 6'sd1;
    end else if (v < 0) begin
      return v + 6'sd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/ball_step.sv
// Combinational move / cushion bounce / friction for a single ball.
module ball_step
  import pool_ball_pkg::*;
(
  input  ball_state_t ball_i,
  input  coord_t      x_min_i,
  input  coord_t      x_max_i,
  input  coord_t      y_min_i,
  input  coord_t      y_max_i,
  input  logic        friction_en_i,
  output ball_state_t ball_o
);

  // Positions are widened to 12-bit signed so a step past either cushion is still ordered correctly.
  logic signed [11:0] new_x;
  logic signed [11:0] new_y;
  vel_t               vx_b;
  vel_t               vy_b;

  assign new_x = $signed({1'b0, ball_i.x}) + $signed({{6{ball_i.vx[5]}}, ball_i.vx});
  assign new_y = $signed({1'b0, ball_i.y}) + $signed({{6{ball_i.vy[5]}}, ball_i.vy});

  // Clamp to the cushion and reflect velocity, then apply friction to the post-bounce velocity.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    ball_o = ball_i;
    vx_b   = ball_i.vx;
    vy_b   = ball_i.vy;

    ball_o.x = new_x[10:0];
    if (new_x < $signed({1'b0, x_min_i})) begin
      ball_o.x = x_min_i;
      vx_b     = neg_sat(ball_i.vx);
    end else if (new_x > $signed({1'b0, x_max_i})) begin
      ball_o.x = x_max_i;
      vx_b     = neg_sat(ball_i.vx);
    end

    ball_o.y = new_y[10:0];
    if (new_y < $signed({1'b0, y_min_i})) begin
      ball_o.y = y_min_i;
      vy_b     = neg_sat(ball_i.vy);
    end else if (new_y > $signed({1'b0, y_max_i})) begin
      ball_o.y = y_max_i;
      vy_b     = neg_sat(ball_i.vy);
    end

    ball_o.vx = friction_en_i ? toward_zero(vx_b) : vx_b;
    ball_o.vy = friction_en_i ? toward_zero(vy_b) : vy_b;
  end

endmodule

// File: rtl/ball_motion_scheduler.sv
// Frame-synchronous ball motion controller: one shared ball_step datapath, one ball per cycle,
// centers published atomically once every ball of the frame has been stepped.
module ball_motion_scheduler
  import pool_ball_pkg::*;
#(
  parameter int NUM_BALLS       = 4,
  parameter int BALL_RADIUS     = 16,
  parameter int TABLE_LEFT      = 32,
  parameter int TABLE_RIGHT     = 607,
  parameter int TABLE_TOP       = 32,
  parameter int TABLE_BOTTOM    = 447,
  parameter int INIT_X0         = 160,
  parameter int INIT_SPACING    = 64,
  parameter int INIT_Y          = 240,
  parameter int FRICTION_PERIOD = 8
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              hitValid,
  output logic              hitReady,
  input  logic [2:0]        hitIndex,
  input  logic signed [5:0] hitVX,
  input  logic signed [5:0] hitVY,
  output logic [10:0]       centerX [NUM_BALLS],
  output logic [10:0]       centerY [NUM_BALLS],
  output logic              busy,
  output logic              allStopped
);

  localparam int     IDX_W = $clog2(NUM_BALLS);
  localparam int     FC_W  = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
  localparam coord_t X_MIN = coord_t'(TABLE_LEFT + BALL_RADIUS);
  localparam coord_t X_MAX = coord_t'(TABLE_RIGHT - BALL_RADIUS);
  localparam coord_t Y_MIN = coord_t'(TABLE_TOP + BALL_RADIUS);
  localparam coord_t Y_MAX = coord_t'(TABLE_BOTTOM - BALL_RADIUS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BALLS - 1);
  localparam logic [FC_W-1:0]  LAST_FRAME = FC_W'(FRICTION_PERIOD - 1);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pending_q, pending_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              busy_q, hit_ready_q, all_stopped_q;
  logic              publish;
  logic              stopped_now;

  ball_state_t       balls_q    [NUM_BALLS];
  coord_t            center_x_q [NUM_BALLS];
  coord_t            center_y_q [NUM_BALLS];

  ball_state_t       step_in, step_out;
  logic              friction_en;
  logic              hit_accept;
  logic [IDX_W-1:0]  hit_sel;

  assign hit_sel     = hitIndex[IDX_W-1:0];
  // Out-of-range indices still complete the handshake; they simply write nothing.
  assign hit_accept  = hitValid && (state_q == IDLE) && ({1'b0, hitIndex} < 4'(NUM_BALLS));
  assign friction_en = (frame_cnt_q == LAST_FRAME);
  assign step_in     = balls_q[idx_q];

  ball_step u_ball_step (
    .ball_i        (step_in),
    .x_min_i       (X_MIN),
    .x_max_i       (X_MAX),
    .y_min_i       (Y_MIN),
    .y_max_i       (Y_MAX),
    .friction_en_i (friction_en),
    .ball_o        (step_out)
  );

  // Next-state logic: IDLE waits for a frame, UPDATE walks the balls, DONE publishes.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    publish     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (startOfFrame || pending_q) begin
          state_d   = UPDATE;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      UPDATE: begin
        if (startOfFrame) pending_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (startOfFrame) pending_d = 1'b1;
        publish     = 1'b1;
        frame_cnt_d = (frame_cnt_q == LAST_FRAME) ? '0 : frame_cnt_q + 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every ball velocity zero, evaluated on the shadow state that DONE is about to publish.
  always_comb begin
    stopped_now = 1'b1;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (balls_q[i].vx != '0 || balls_q[i].vy != '0) stopped_now = 1'b0;
    end
  end

  // Scheduler state and registered status outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      frame_cnt_q   <= '0;
      busy_q        <= 1'b0;
      hit_ready_q   <= 1'b1;
      all_stopped_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= (state_d != IDLE);
      hit_ready_q <= (state_d == IDLE);
      if (publish) all_stopped_q <= stopped_now;
    end
  end

  // Shadow ball state: strikes load velocity in IDLE, the shared datapath rewrites one ball per UPDATE cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      // NOTE: this small register array is reset element by element because reset places every ball.
      for (int i = 0; i < NUM_BALLS; i++) begin
        balls_q[i] <= '{x: coord_t'(INIT_X0 + i * INIT_SPACING), y: coord_t'(INIT_Y), vx: '0, vy: '0};
      end
    end else if (hit_accept) begin
      balls_q[hit_sel].vx <= hitVX;
      balls_q[hit_sel].vy <= hitVY;
    end else if (state_q == UPDATE) begin
      balls_q[idx_q] <= step_out;
    end
  end

  // Published centers change only on the DONE edge, so consumers never see a half-stepped frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        center_x_q[i] <= coord_t'(INIT_X0 + i * INIT_SPACING);
        center_y_q[i] <= coord_t'(INIT_Y);
      end
    end else if (publish) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        center_x_q[i] <= balls_q[i].x;
        center_y_q[i] <= balls_q[i].y;
      end
    end
  end

  assign centerX    = center_x_q;
  assign centerY    = center_y_q;
  assign busy       = busy_q;
  assign hitReady   = hit_ready_q;
  assign allStopped = all_stopped_q;

endmodule

// File: tb/tb_ball_motion_scheduler.sv
// Directed bench for ball_motion_scheduler: table of strike/frame vectors plus hand-written
// sequences for frame timing, overrun handling and mid-update reset.
module tb_ball_motion_scheduler;

  localparam int NB = 4;

  logic              clk = 1'b0;
  logic              resetN = 1'b0;
  logic              startOfFrame = 1'b0;
  logic              hitValid = 1'b0;
  logic              hitReady;
  logic [2:0]        hitIndex = '0;
  logic signed [5:0] hitVX = '0;
  logic signed [5:0] hitVY = '0;
  logic [10:0]       centerX [NB];
  logic [10:0]       centerY [NB];
  logic              busy;
  logic              allStopped;

  int n_checks = 0;
  int n_errors = 0;

  ball_motion_scheduler #(.NUM_BALLS(NB)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .hitValid     (hitValid),
    .hitReady     (hitReady),
    .hitIndex     (hitIndex),
    .hitVX        (hitVX),
    .hitVY        (hitVY),
    .centerX      (centerX),
    .centerY      (centerY),
    .busy         (busy),
    .allStopped   (allStopped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int vx;
    int vy;
    int frames;
    int ball;
    int ex;
    int ey;
    int es;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    startOfFrame = 1'b0;
    hitValid     = 1'b0;
    resetN       = 1'b0;
    @(posedge clk); #1;
    resetN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic strike(input int idx, input int vx, input int vy);
    hitValid = 1'b1;
    hitIndex = 3'(idx);
    hitVX    = 6'(vx);
    hitVY    = 6'(vy);
    @(posedge clk); #1;
    hitValid = 1'b0;
  endtask

  // One startOfFrame pulse, then wait (bounded) until the frame has been published.
  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      int w;
      startOfFrame = 1'b1;
      @(posedge clk); #1;
      startOfFrame = 1'b0;
      w = 0;
      while (busy && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      if (busy) check("frame_timeout", int'(busy), 0);
    end
  endtask

  initial begin
    // {hit ball, vx, vy, frames, ball to inspect, expected X, expected Y, expected allStopped}
    vecs[0]  = '{1,   5,  -3,  1, 1, 229, 237, 0};  // basic move
    vecs[1]  = '{3,  31,   0,  8, 3, 591, 240, 0};  // right cushion + friction same frame
    vecs[2]  = '{3,  31,   0,  9, 3, 561, 240, 0};  // after bounce, VX=-30
    vecs[3]  = '{0, -32,   0,  4, 0,  48, 240, 0};  // left cushion, -(-32)=+31
    vecs[4]  = '{0, -32,   0,  5, 0,  79, 240, 0};  // moving right at +31
    vecs[5]  = '{2,   0,  31,  8, 2, 288, 400, 0};  // bottom cushion at frame 7, friction at 8
    vecs[6]  = '{1,   0, -32,  7, 1, 224,  48, 0};  // top cushion
    vecs[7]  = '{1,   0, -32,  8, 1, 224,  79, 0};  // back down at +31
    vecs[8]  = '{2,   4,   0, 31, 2, 367, 240, 0};  // friction still leaves VX=1
    vecs[9]  = '{2,   4,   0, 32, 2, 368, 240, 1};  // friction reaches zero
    vecs[10] = '{5,  10,  10,  1, 0, 160, 240, 1};  // out-of-range index discarded

    // Reset state
    do_reset();
    for (int j = 0; j < NB; j++) begin
      check($sformatf("reset_cx%0d", j), int'(centerX[j]), 160 + 64 * j);
      check($sformatf("reset_cy%0d", j), int'(centerY[j]), 240);
    end
    check("reset_allStopped", int'(allStopped), 1);
    check("reset_hitReady", int'(hitReady), 1);
    check("reset_busy", int'(busy), 0);

    // Table-driven vectors
    for (int v = 0; v < 11; v++) begin
      do_reset();
      strike(vecs[v].idx, vecs[v].vx, vecs[v].vy);
      run_frames(vecs[v].frames);
      check($sformatf("v%0d_cx", v), int'(centerX[vecs[v].ball]), vecs[v].ex);
      check($sformatf("v%0d_cy", v), int'(centerY[vecs[v].ball]), vecs[v].ey);
      check($sformatf("v%0d_stopped", v), int'(allStopped), vecs[v].es);
      for (int j = 0; j < NB; j++) begin
        if (j != vecs[v].ball) begin
          check($sformatf("v%0d_other_cx%0d", v, j), int'(centerX[j]), 160 + 64 * j);
          check($sformatf("v%0d_other_cy%0d", v, j), int'(centerY[j]), 240);
        end
      end
    end

    // Frame timing with a strike in the same cycle as startOfFrame
    do_reset();
    hitValid = 1'b1; hitIndex = 3'd1; hitVX = 6'sd5; hitVY = -6'sd3;
    startOfFrame = 1'b1;
    @(posedge clk); #1;                                   // edge t
    hitValid = 1'b0; startOfFrame = 1'b0;
    check("t1_busy", int'(busy), 1);
    check("t1_hitReady", int'(hitReady), 0);
    repeat (NB) begin @(posedge clk); #1; end             // now at t+NB+1 (DONE)
    check("done_busy", int'(busy), 1);
    check("done_cx1_unchanged", int'(centerX[1]), 224);
    check("done_cy1_unchanged", int'(centerY[1]), 240);
    @(posedge clk); #1;                                   // t+NB+2
    check("pub_cx1", int'(centerX[1]), 229);
    check("pub_cy1", int'(centerY[1]), 237);
    check("pub_busy", int'(busy), 0);
    check("pub_hitReady", int'(hitReady), 1);
    check("pub_stopped", int'(allStopped), 0);

    // Overrun: second pulse pending, third dropped, strike during update ignored
    do_reset();
    strike(1, 5, 0);
    startOfFrame = 1'b1;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    begin
      int busy_cycles = 0;
      for (int k = 0; k < 30; k++) begin
        if (busy) busy_cycles++;
        startOfFrame = (k == 1 || k == 2);
        hitValid     = (k == 2);
        hitIndex     = 3'd2;
        hitVX        = 6'sd7;
        hitVY        = 6'sd0;
        if (k == 1) begin
          check("ovr_hitReady", int'(hitReady), 0);
          check("ovr_busy", int'(busy), 1);
        end
        @(posedge clk); #1;
      end
      startOfFrame = 1'b0;
      hitValid     = 1'b0;
      check("ovr_busy_cycles", busy_cycles, 2 * (NB + 1));
    end
    check("ovr_cx1", int'(centerX[1]), 234);
    check("ovr_cx2_no_hit", int'(centerX[2]), 288);
    check("ovr_stopped", int'(allStopped), 0);

    // Reset asserted while the update is at ball index 2
    do_reset();
    strike(0, 5, 0);
    run_frames(1);
    check("pre_rst_cx0", int'(centerX[0]), 165);
    startOfFrame = 1'b1;
    @(posedge clk); #1;                                   // t+1, idx 0; pulse again to set pending
    @(posedge clk); #1;                                   // t+2, idx 1
    startOfFrame = 1'b0;
    @(posedge clk); #1;                                   // t+3, idx 2
    resetN = 1'b0;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_hitReady", int'(hitReady), 1);
    check("rst_mid_stopped", int'(allStopped), 1);
    check("rst_mid_cx0", int'(centerX[0]), 160);
    check("rst_mid_cy0", int'(centerY[0]), 240);
    @(posedge clk); #1;
    resetN = 1'b1;
    begin
      int bc = 0;
      for (int k = 0; k < 8; k++) begin
        if (busy) bc++;
        @(posedge clk); #1;
      end
      check("rst_pending_cleared", bc, 0);
    end
    run_frames(1);
    check("post_rst_cx0", int'(centerX[0]), 160);
    check("post_rst_stopped", int'(allStopped), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
